// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD line: receiver states, CRC7 polynomial,
// response field positions and default response lengths.
package sd_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_START = 2'd1,
      ST_RECEIVE    = 2'd2,
      ST_DONE       = 2'd3
   } rx_state_t;

   localparam logic [6:0] CRC7_POLY = 7'h09;

   // Start and transmission bits are counted down from the frame MSB.
   localparam int START_FROM_MSB  = 0;
   localparam int TX_BIT_FROM_MSB = 1;
   localparam int CRC_MSB         = 7;
   localparam int CRC_LSB         = 1;
   localparam int END_BIT         = 0;

   localparam int RESP_LEN_SHORT  = 48;
   localparam int RESP_LEN_LONG   = 136;
   localparam int NCR_TIMEOUT_CYC = 64;

   // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first.
   function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
      logic fb;
      fb = crc[6] ^ bit_in;
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/cmd_response_deserializer_if.sv
// Handshake/status bundle between the SD host controller and the CMD response receiver.
interface cmd_response_deserializer_if #(
   parameter int RESP_WIDTH = 48
);
   logic                  enable;
   logic                  cmd_in;
   logic [RESP_WIDTH-1:0] parallel;
   logic                  complete;
   logic                  crc_error;
   logic                  frame_error;
   logic                  timeout;

   modport master (
      output enable, cmd_in,
      input  parallel, complete, crc_error, frame_error, timeout
   );

   modport slave (
      input  enable, cmd_in,
      output parallel, complete, crc_error, frame_error, timeout
   );
endinterface

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 accumulator, shared by the CMD transmit and receive paths.
module crc7_serial
   import sd_cmd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       enable,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic [6:0] crc_r;

   // CRC accumulator; clear takes priority over a shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_r <= 7'h00;
      end else if (clear) begin
         crc_r <= 7'h00;
      end else if (enable) begin
         crc_r <= crc7_next(crc_r, bit_in);
      end else begin
         crc_r <= crc_r;
      end
   end

   assign crc = crc_r;

endmodule

// File: rtl/cmd_response_deserializer.sv
// SD CMD line response receiver: waits for the start bit, shifts the frame in
// MSB-first, then reports the frame with CRC7/framing/timeout status.
module cmd_response_deserializer
   import sd_cmd_pkg::*;
#(
   parameter int RESP_WIDTH  = RESP_LEN_SHORT,
   parameter int TIMEOUT_CYC = NCR_TIMEOUT_CYC,
   parameter bit CRC_EN      = 1'b1
) (
   input  logic                      sd_clock,
   input  logic                      reset,
   cmd_response_deserializer_if.slave bus
);

   localparam int BW        = $clog2(RESP_WIDTH);
   localparam int WW        = $clog2(TIMEOUT_CYC + 1);
   localparam int START_POS = RESP_WIDTH - 1 - START_FROM_MSB;
   localparam int TX_POS    = RESP_WIDTH - 1 - TX_BIT_FROM_MSB;
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(RESP_WIDTH - 1);
   localparam logic [BW-1:0] CRC_LIMIT = BW'(RESP_WIDTH - 8);
   localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);

   rx_state_t             state_r, state_s;
   logic [RESP_WIDTH-1:0] shift_r, parallel_r;
   logic [BW-1:0]         bit_cnt_r, bit_num_s;
   logic [WW-1:0]         wait_cnt_r;
   logic                  complete_r, crc_error_r, frame_error_r, timeout_r;
   logic                  crc_clear_s, crc_en_s, crc_bad_s, frame_bad_s;
   logic [6:0]            crc_s;

   assign bit_num_s = bit_cnt_r + BIT_ONE;

   crc7_serial u_crc (
      .clk    (sd_clock),
      .rst    (reset),
      .clear  (crc_clear_s),
      .enable (crc_en_s),
      .bit_in (bus.cmd_in),
      .crc    (crc_s)
   );

   // Next-state decode; enable low always returns to IDLE
   always_comb begin
      state_s = state_r;
      if (!bus.enable) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:       state_s = ST_WAIT_START;
            ST_WAIT_START: begin
               if (!bus.cmd_in) begin
                  state_s = ST_RECEIVE;
               end else if (wait_cnt_r == WAIT_LAST) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_WAIT_START;
               end
            end
            ST_RECEIVE: begin
               if (bit_num_s == BIT_LAST) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_RECEIVE;
               end
            end
            ST_DONE:       state_s = ST_DONE;
            default:       state_s = ST_IDLE;
         endcase
      end
   end

   // CRC control and end-of-frame checks; CRC covers the start bit up to the CRC field
   always_comb begin
      crc_clear_s = (state_r == ST_IDLE);
      crc_en_s    = 1'b0;
      if (!bus.enable) begin
         crc_en_s = 1'b0;
      end else if (state_r == ST_WAIT_START) begin
         crc_en_s = !bus.cmd_in;
      end else if (state_r == ST_RECEIVE) begin
         crc_en_s = (bit_num_s < CRC_LIMIT);
      end else begin
         crc_en_s = 1'b0;
      end
      if (CRC_EN) begin
         crc_bad_s = (crc_s != shift_r[CRC_MSB:CRC_LSB]);
      end else begin
         crc_bad_s = 1'b0;
      end
      frame_bad_s = shift_r[START_POS] | shift_r[TX_POS] | ~shift_r[END_BIT];
   end

   // State, shift register, counters and status registers
   always_ff @(posedge sd_clock or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         shift_r       <= {RESP_WIDTH{1'b0}};
         parallel_r    <= {RESP_WIDTH{1'b0}};
         bit_cnt_r     <= {BW{1'b0}};
         wait_cnt_r    <= {WW{1'b0}};
         complete_r    <= 1'b0;
         crc_error_r   <= 1'b0;
         frame_error_r <= 1'b0;
         timeout_r     <= 1'b0;
      end else begin
         state_r <= state_s;
         if (!bus.enable) begin
            complete_r    <= 1'b0;
            crc_error_r   <= 1'b0;
            frame_error_r <= 1'b0;
            timeout_r     <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  wait_cnt_r    <= {WW{1'b0}};
                  bit_cnt_r     <= {BW{1'b0}};
                  complete_r    <= 1'b0;
                  crc_error_r   <= 1'b0;
                  frame_error_r <= 1'b0;
                  timeout_r     <= 1'b0;
               end
               ST_WAIT_START: begin
                  // A start bit on the expiry edge wins over the timeout
                  if (!bus.cmd_in) begin
                     shift_r   <= {shift_r[RESP_WIDTH-2:0], 1'b0};
                     bit_cnt_r <= {BW{1'b0}};
                  end else if (wait_cnt_r == WAIT_LAST) begin
                     complete_r    <= 1'b1;
                     timeout_r     <= 1'b1;
                     crc_error_r   <= 1'b0;
                     frame_error_r <= 1'b0;
                  end else begin
                     wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                  end
               end
               ST_RECEIVE: begin
                  shift_r   <= {shift_r[RESP_WIDTH-2:0], bus.cmd_in};
                  bit_cnt_r <= bit_num_s;
               end
               ST_DONE: begin
                  // Publish once; a timeout has already set complete and skips this
                  if (!complete_r) begin
                     parallel_r    <= shift_r;
                     complete_r    <= 1'b1;
                     crc_error_r   <= crc_bad_s;
                     frame_error_r <= frame_bad_s;
                  end
               end
               default: begin
                  complete_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.parallel    = parallel_r;
   assign bus.complete    = complete_r;
   assign bus.crc_error   = crc_error_r;
   assign bus.frame_error = frame_error_r;
   assign bus.timeout     = timeout_r;

endmodule
